// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side handshake and the FIFO write-port signals seen by
//   fifo_wr_arbiter.
//
//   Signals
//     req_valid   [NUM_REQ]          per-producer beat valid
//     req_data    [NUM_REQ*DATA_W]   producer i data at [i*DATA_W +: DATA_W]
//     req_ready   [NUM_REQ]          per-producer beat accepted (one-hot or zero)
//     fifo_full                      FIFO full flag
//     fifo_empty                     FIFO empty flag
//     fifo_rd                        read strobe going to the FIFO this cycle
//     fifo_wr                        FIFO write strobe
//     fifo_din    [DATA_W]           FIFO write data
//     grant_id    [$clog2(NUM_REQ)]  current/last granted producer
//     busy                           high while a producer holds the grant
//
//   Modports
//     slave   the arbiter itself
//     master  the environment: producers plus FIFO status/read side
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_rd;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_din;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_empty, fifo_rd,
    output req_ready, fifo_wr, fifo_din, grant_id, busy
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_empty, fifo_rd,
    input  req_ready, fifo_wr, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of a 16 x 8 FIFO among
//   NUM_REQ producers. One producer is granted at a time for a burst of up to
//   MAX_BURST beats. Writes the FIFO would drop (full, or a read that wins over
//   the write because rd && !empty) are held back instead of being issued.
//
//   Ports
//     clk   in   system clock, rising edge
//     rst   in   asynchronous reset, active-high
//     bus   slave side of fifo_wr_arbiter_if (producer handshake, FIFO write
//           port, FIFO status/read strobe, grant_id, busy)
//
//   Parameters
//     NUM_REQ    number of producers (>= 2)
//     DATA_W     data width, matches FIFO din
//     MAX_BURST  beats per grant before forced re-arbitration (>= 1)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q,    state_d;
  logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  // (base + off) mod NUM_REQ without a divider; off is always < NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(off);
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    return sum[ID_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate req_valid so that bit 0 is the producer at rr_ptr,
  // then take the lowest set bit of the rotated vector.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_found;

  assign dbl_valid = {bus.req_valid, bus.req_valid};
  assign rot_valid = NUM_REQ'(dbl_valid >> rr_ptr_q);

  // NOTE: every signal written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    pick_id    = rr_ptr_q;
    pick_found = 1'b0;
    // Walk from the far end down so the nearest requester is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        pick_found = 1'b1;
        pick_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted producer datapath
  // ---------------------------------------------------------------------------
  logic              cur_valid;
  logic [DATA_W-1:0] cur_data;
  logic              blocked;
  logic              accept;
  logic              last_beat;

  assign cur_valid = bus.req_valid[grant_id_q];

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) cur_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // A read of a non-empty FIFO wins over a write in the same cycle, so such a
  // write would be lost; a read of an empty FIFO is ignored and does not block.
  assign blocked   = bus.fifo_full | (bus.fifo_rd & ~bus.fifo_empty);
  assign accept    = (state_q == ST_GRANT) & cur_valid & ~blocked;
  assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Arbitration takes the whole cycle; no beat is accepted here.
        if (pick_found) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!cur_valid) begin
          // Producer has nothing more: release without taking a beat.
          state_d  = ST_IDLE;
          rr_ptr_d = wrap_add(grant_id_q, 1);
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_add(grant_id_q, 1);
          end
        end
        // valid but blocked: hold the grant indefinitely, count unchanged.
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All strobes derive from accept, which depends on state_q; the
  // async reset forces state_q to IDLE so they drop without waiting for a clock.
  // ---------------------------------------------------------------------------
  assign bus.req_ready = NUM_REQ'(accept) << grant_id_q;
  assign bus.fifo_wr   = accept;
  assign bus.fifo_din  = accept ? cur_data : '0;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q == ST_GRANT);

endmodule
